// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline stall/flush control with multicycle mul/div sequencing
module hazard_controller #(
  parameter int MD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs_ID,
  input  logic [4:0]  Rt_ID,
  input  logic [4:0]  RdOrRt_EX,
  input  logic [4:0]  RdOrRt_M,
  input  logic        RegWrite_EX,
  input  logic        MemtoReg_EX,
  input  logic        MemtoReg_M,
  input  logic        Branch_ID,
  input  logic        Jump_ID,
  input  logic        BranchTaken_ID,
  input  logic        MulDiv_EX,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        MdStart,
  output logic        MdDone,
  output logic        MdBusy,
  output logic [15:0] StallCount
);

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  logic       state, state_next;
  logic [4:0] cnt, cnt_next;
  logic       lwstall, branchstall, ex_match, m_match;

  assign ex_match = (RdOrRt_EX != 5'd0) && ((RdOrRt_EX == Rs_ID) || (RdOrRt_EX == Rt_ID));
  assign m_match  = (RdOrRt_M  != 5'd0) && ((RdOrRt_M  == Rs_ID) || (RdOrRt_M  == Rt_ID));

  assign lwstall     = MemtoReg_EX && ex_match;
  assign branchstall = Branch_ID && ((RegWrite_EX && ex_match) || (MemtoReg_M && m_match));

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    FlushE     = 1'b0;
    FlushM     = 1'b0;
    MdStart    = 1'b0;
    MdDone     = 1'b0;
    case (state)
      IDLE: begin
        if (MulDiv_EX) begin
          MdStart    = 1'b1;
          StallF     = 1'b1;
          StallD     = 1'b1;
          StallE     = 1'b1;
          FlushM     = 1'b1;
          cnt_next   = 5'(MD_CYCLES - 2);
          state_next = BUSY;
        end else begin
          StallF = lwstall || branchstall;
          StallD = lwstall || branchstall;
          FlushE = lwstall || branchstall;
        end
      end
      default: begin
        if (cnt != 5'd0) begin
          StallF   = 1'b1;
          StallD   = 1'b1;
          StallE   = 1'b1;
          FlushM   = 1'b1;
          cnt_next = cnt - 5'd1;
        end else begin
          // A reset landing on the final cycle aborts the op, so no completion pulse
          MdDone     = !rst;
          state_next = IDLE;
        end
      end
    endcase
  end

  assign FlushD = (BranchTaken_ID || Jump_ID) && !StallD;
  assign MdBusy = (state == BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      StallCount <= 16'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (StallF && (StallCount != 16'hFFFF))
        StallCount <= StallCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - self-checking bench for hazard_controller
module tb_hazard_controller;

  localparam int MD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs_ID, Rt_ID, RdOrRt_EX, RdOrRt_M;
  logic        RegWrite_EX, MemtoReg_EX, MemtoReg_M;
  logic        Branch_ID, Jump_ID, BranchTaken_ID, MulDiv_EX;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic        MdStart, MdDone, MdBusy;
  logic [15:0] StallCount;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  hazard_controller #(.MD_CYCLES(MD)) dut (
    .clk(clk), .rst(rst),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .RdOrRt_EX(RdOrRt_EX), .RdOrRt_M(RdOrRt_M),
    .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX), .MemtoReg_M(MemtoReg_M),
    .Branch_ID(Branch_ID), .Jump_ID(Jump_ID), .BranchTaken_ID(BranchTaken_ID),
    .MulDiv_EX(MulDiv_EX),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .MdStart(MdStart), .MdDone(MdDone), .MdBusy(MdBusy), .StallCount(StallCount)
  );

  // Model: phase 0 = no op in flight, 1..MD-1 = cycles of the op after the start cycle
  int phase = 0;
  int exp_count = 0;
  logic lw, br, haz, md_start, md_hold;
  logic e_sf, e_sd, e_se, e_fd, e_fe, e_fm, e_done, e_busy;

  always_comb begin
    lw       = MemtoReg_EX && RdOrRt_EX != 0 && (RdOrRt_EX == Rs_ID || RdOrRt_EX == Rt_ID);
    br       = Branch_ID && ((RegWrite_EX && RdOrRt_EX != 0 && (RdOrRt_EX == Rs_ID || RdOrRt_EX == Rt_ID)) ||
                             (MemtoReg_M && RdOrRt_M != 0 && (RdOrRt_M == Rs_ID || RdOrRt_M == Rt_ID)));
    md_start = (phase == 0) && MulDiv_EX;
    haz      = (phase == 0) && !MulDiv_EX && (lw || br);
    md_hold  = md_start || (phase >= 1 && phase < MD - 1);
    e_sf     = md_hold || haz;
    e_sd     = e_sf;
    e_se     = md_hold;
    e_fe     = haz;
    e_fm     = md_hold;
    e_done   = (phase == MD - 1) && !rst;
    e_busy   = (phase != 0);
    e_fd     = (BranchTaken_ID || Jump_ID) && !e_sd;
  end

  always @(posedge clk) begin
    if (rst) begin
      phase     <= 0;
      exp_count <= 0;
    end else begin
      if (e_sf && exp_count < 65535) exp_count <= exp_count + 1;
      if (phase == 0)           phase <= MulDiv_EX ? 1 : 0;
      else if (phase == MD - 1) phase <= 0;
      else                      phase <= phase + 1;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("StallF",     16'(StallF),  16'(e_sf));
      chk("StallD",     16'(StallD),  16'(e_sd));
      chk("StallE",     16'(StallE),  16'(e_se));
      chk("FlushD",     16'(FlushD),  16'(e_fd));
      chk("FlushE",     16'(FlushE),  16'(e_fe));
      chk("FlushM",     16'(FlushM),  16'(e_fm));
      chk("MdStart",    16'(MdStart), 16'(md_start));
      chk("MdDone",     16'(MdDone),  16'(e_done));
      chk("MdBusy",     16'(MdBusy),  16'(e_busy));
      chk("StallCount", StallCount,   16'(exp_count));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs_ID = 0; Rt_ID = 0; RdOrRt_EX = 0; RdOrRt_M = 0;
    RegWrite_EX = 0; MemtoReg_EX = 0; MemtoReg_M = 0;
    Branch_ID = 0; Jump_ID = 0; BranchTaken_ID = 0; MulDiv_EX = 0;
  endtask

  task automatic set_loaduse();
    MemtoReg_EX = 1; RdOrRt_EX = 8; Rs_ID = 8;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    tick(); tick();
    rst = 0;
    chk_en = 1;
    #2;
    chk("rst StallCount", StallCount, 16'd0);
    chk("rst outs", {StallF, StallD, StallE, FlushD, FlushE, FlushM, MdStart, MdDone, MdBusy}, 16'd0);

    // Load-use, with a taken branch that must be suppressed by the stall
    tick();
    set_loaduse(); BranchTaken_ID = 1;
    #2;
    chk("lw stall", {StallF, StallD, FlushE, StallE, FlushD}, 16'b11100);
    tick();
    chk("lw count", StallCount, 16'd1);

    clear_inputs();
    Branch_ID = 1; RegWrite_EX = 1; RdOrRt_EX = 9; Rt_ID = 9;
    #2;
    chk("br ex stall", {StallF, FlushE}, 16'b11);
    tick();
    RegWrite_EX = 0; BranchTaken_ID = 1;
    #2;
    chk("br taken", {StallF, FlushD}, 16'b01);
    tick();
    clear_inputs();
    Branch_ID = 1; MemtoReg_M = 1; RdOrRt_M = 5; Rs_ID = 5;
    #2;
    chk("br m stall", {StallF, FlushE}, 16'b11);
    tick();
    chk("br count", StallCount, 16'd3);

    clear_inputs();
    MemtoReg_EX = 1; RdOrRt_EX = 0; Rs_ID = 0;
    #2;
    chk("reg0", {StallF, StallD, FlushE, FlushD}, 16'd0);
    tick();
    clear_inputs();
    Jump_ID = 1;
    #2;
    chk("jump", 16'(FlushD), 16'd1);
    tick();

    clear_inputs();
    MulDiv_EX = 1;
    for (int i = 0; i < MD; i++) begin
      #2;
      chk("md pat", {MdStart, StallF, StallE, FlushM, MdDone, MdBusy},
          {15'd0, i == 0} << 5 | {15'd0, i < MD - 1} << 4 | {15'd0, i < MD - 1} << 3 |
          {15'd0, i < MD - 1} << 2 | {15'd0, i == MD - 1} << 1 | {15'd0, i != 0});
      tick();
      if (i == MD - 1) MulDiv_EX = 0;
    end
    #2;
    chk("md idle", 16'(MdBusy), 16'd0);
    chk("md count", StallCount, 16'd10);

    // Load-use hidden behind an op, taking effect once the op completes
    tick();
    MulDiv_EX = 1; set_loaduse();
    for (int i = 0; i < MD; i++) begin
      #2;
      chk("ovl flushE", {FlushE, StallF}, {15'd0, i < MD - 1});
      tick();
      if (i == MD - 1) MulDiv_EX = 0;
    end
    #2;
    chk("ovl lw", {StallF, FlushE}, 16'b11);
    tick();
    chk("ovl count", StallCount, 16'd18);

    clear_inputs();
    MulDiv_EX = 1;
    tick(); tick(); tick();
    rst = 1;
    tick();
    rst = 0; MulDiv_EX = 0;
    #2;
    chk("rst busy outs", {StallF, StallD, StallE, FlushD, FlushE, FlushM, MdStart, MdDone, MdBusy}, 16'd0);
    chk("rst busy count", StallCount, 16'd0);
    tick(); tick();

    set_loaduse();
    repeat (65540) tick();
    chk("sat count", StallCount, 16'hFFFF);
    tick();
    clear_inputs();
    #2;
    chk("sat hold", StallCount, 16'hFFFF);
    tick();

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
